// File: rtl/iter_alu.sv
// ----------------------------------------------------------------------------
// iter_alu : multi-cycle ALU with valid/ready handshakes on both sides.
//
// Executes the 4-bit data-processing opcode set in one cycle, unsigned
// multiply iteratively (shift-add, one bit per cycle) and, when the
// ITER_ALU_DIV_EN macro is defined, unsigned divide (restoring, one quotient
// bit per cycle). Holds the NZCV flag register that supplies carry-in.
//
// Optional feature macro: ITER_ALU_DIV_EN (divider datapath + UDIV opcode).
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   in_valid/in_ready request handshake (in_ready high only while idle)
//   op, set_flags     operation select, update flags when result is accepted
//   src0, src1        operands A and B
//   out_valid/out_ready result handshake
//   result            registered result
//   flags             current flag register {N,Z,C,V}
//   res_flags         flags computed for the pending result {N,Z,C,V}
//   div_by_zero       pending result is a divide by zero
// ----------------------------------------------------------------------------
module iter_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] src0,
    input  logic [WIDTH-1:0] src1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [3:0]       res_flags,
    output logic             div_by_zero
);

    localparam int unsigned SW = WIDTH + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_EOR  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_RSB  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_ADC  = 4'b0101;
    localparam logic [3:0] OP_SBC  = 4'b0110;
    localparam logic [3:0] OP_RSC  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_UDIV = 4'b1001;
    localparam logic [3:0] OP_CMP  = 4'b1010;
    localparam logic [3:0] OP_RSV  = 4'b1011;
    localparam logic [3:0] OP_ORR  = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1101;
    localparam logic [3:0] OP_BIC  = 4'b1110;
    localparam logic [3:0] OP_MVN  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic [3:0]         flags_q;
    logic [3:0]         res_flags_q;
    logic               dbz_q;
    logic               setf_q;
    logic [CNT_W-1:0]   cnt_q;
    // Shared iteration registers: multiplicand/divisor, multiplier/quotient,
    // accumulator/remainder.
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   acc_q;

    // N and Z from a result; C and V cleared (MUL/UDIV/logic results).
    function automatic logic [3:0] nz_flags(input logic [WIDTH-1:0] r);
        return {r[WIDTH-1], (r == '0), 2'b00};
    endfunction

    // ------------------------------------------------------------------
    // Single-cycle datapath: one WIDTH+1 adder covers every add/subtract
    // form by feeding it (x, y, carry-in); subtracts use y = ~subtrahend.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] add_x_d;
    logic [WIDTH-1:0] add_y_d;
    logic             add_ci_d;
    logic             is_arith_d;
    logic [WIDTH-1:0] logic_res_d;
    logic [SW-1:0]    add_sum_d;
    logic [WIDTH-1:0] sc_res_d;
    logic [3:0]       sc_flags_d;
    logic             sc_defined_d;

    always_comb begin
        add_x_d     = src0;
        add_y_d     = src1;
        add_ci_d    = 1'b0;
        is_arith_d  = 1'b0;
        logic_res_d = '0;
        case (op)
            OP_AND: logic_res_d = src0 & src1;
            OP_EOR: logic_res_d = src0 ^ src1;
            OP_ORR: logic_res_d = src0 | src1;
            OP_MOV: logic_res_d = src1;
            OP_BIC: logic_res_d = src0 & ~src1;
            OP_MVN: logic_res_d = ~src1;
            OP_ADD: is_arith_d = 1'b1;
            OP_ADC: begin
                is_arith_d = 1'b1;
                add_ci_d   = flags_q[1];
            end
            OP_SUB, OP_CMP: begin
                is_arith_d = 1'b1;
                add_y_d    = ~src1;
                add_ci_d   = 1'b1;
            end
            OP_RSB: begin
                is_arith_d = 1'b1;
                add_x_d    = src1;
                add_y_d    = ~src0;
                add_ci_d   = 1'b1;
            end
            OP_SBC: begin
                is_arith_d = 1'b1;
                add_y_d    = ~src1;
                add_ci_d   = flags_q[1];
            end
            OP_RSC: begin
                is_arith_d = 1'b1;
                add_x_d    = src1;
                add_y_d    = ~src0;
                add_ci_d   = flags_q[1];
            end
            default: logic_res_d = '0;
        endcase
    end

    assign add_sum_d    = {1'b0, add_x_d} + {1'b0, add_y_d} + SW'(add_ci_d);
    assign sc_defined_d = !(op == OP_RSV || op == OP_UDIV || op == OP_MUL);

    // Reserved opcodes report zero result and all-zero flags (Z not set).
    always_comb begin
        sc_res_d   = is_arith_d ? add_sum_d[WIDTH-1:0] : logic_res_d;
        sc_flags_d = 4'b0000;
        if (sc_defined_d) begin
            sc_flags_d = nz_flags(sc_res_d);
            if (is_arith_d) begin
                sc_flags_d[1] = add_sum_d[WIDTH];
                sc_flags_d[0] = (add_x_d[WIDTH-1] == add_y_d[WIDTH-1]) &&
                                (add_sum_d[WIDTH-1] != add_x_d[WIDTH-1]);
            end
        end
    end

    // Shift-add multiply step: add multiplicand when current multiplier LSB set.
    logic [WIDTH-1:0] mul_acc_d;
    assign mul_acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef ITER_ALU_DIV_EN
    // Restoring divide step: shift next dividend bit into the remainder,
    // subtract divisor if it fits. A zero divisor always fits, giving all-ones.
    logic [SW-1:0]    rem_sh_d;
    logic             q_bit_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    assign rem_sh_d = {acc_q, mplier_q[WIDTH-1]};
    assign q_bit_d  = (rem_sh_d >= {1'b0, mcand_q});
    assign rem_d    = q_bit_d ? (rem_sh_d[WIDTH-1:0] - mcand_q) : rem_sh_d[WIDTH-1:0];
    assign quo_d    = {mplier_q[WIDTH-2:0], q_bit_d};
`endif

    // ------------------------------------------------------------------
    // Control FSM and all registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= 4'b0000;
            res_flags_q <= 4'b0000;
            dbz_q       <= 1'b0;
            setf_q      <= 1'b0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        setf_q     <= set_flags;
                        cnt_q      <= '0;
                        dbz_q      <= 1'b0;
                        if (op == OP_MUL) begin
                            mcand_q  <= src0;
                            mplier_q <= src1;
                            acc_q    <= '0;
                            state_q  <= S_MUL;
                        end
`ifdef ITER_ALU_DIV_EN
                        else if (op == OP_UDIV) begin
                            mcand_q  <= src1;
                            mplier_q <= src0;
                            acc_q    <= '0;
                            state_q  <= S_DIV;
                        end
`endif
                        else begin
                            result_q    <= sc_res_d;
                            res_flags_q <= sc_flags_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= mul_acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_q    <= mul_acc_d;
                        res_flags_q <= nz_flags(mul_acc_d);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
`ifdef ITER_ALU_DIV_EN
                S_DIV: begin
                    acc_q    <= rem_d;
                    mplier_q <= quo_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_q    <= quo_d;
                        res_flags_q <= nz_flags(quo_d);
                        dbz_q       <= (mcand_q == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        if (setf_q) begin
                            flags_q <= res_flags_q;
                        end
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign flags       = flags_q;
    assign res_flags   = res_flags_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/iter_alu.md
# iter_alu

Multi-cycle, parametrised ALU for the processor datapath. Executes the standard 4-bit data-processing opcode set plus iterative unsigned multiply and (optionally) unsigned divide. Uses valid/ready handshakes on both sides and holds an internal NZCV flag register that supplies the carry-in for carry-using operations. Sits between register-file read and write-back in multi-cycle cores where a multiplier/divider is needed without a combinational array.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4)
- CNT_W, $clog2(WIDTH)+1, iteration counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- op  in  4  operation select
- set_flags  in  1  update flag register when this result is accepted
- src0  in  WIDTH  operand A
- src1  in  WIDTH  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- flags  out  4  current flag register {N,Z,C,V}
- res_flags  out  4  flags computed for the pending result {N,Z,C,V}
- div_by_zero  out  1  pending result is a divide with src1 == 0

## Operation
- Opcodes: 0000 AND, 0001 EOR, 0010 SUB (A−B), 0011 RSB (B−A), 0100 ADD, 0101 ADC, 0110 SBC (A−B−!C), 0111 RSC (B−A−!C), 1000 MUL, 1001 UDIV, 1010 CMP (A−B), 1100 ORR, 1101 MOV (B), 1110 BIC (A & ~B), 1111 MVN (~B), 1011 reserved → result 0, flags 0.
- C for carry-ins is flags[1] sampled at acceptance.
- Arithmetic: add/sub done at WIDTH+1 bits. C = carry-out for add; C = NOT borrow (unsigned minuend ≥ subtrahend + borrow-in) for subtract. V = signed overflow of the WIDTH-bit result. Logic/move/MUL/UDIV: C=0, V=0. N = result[WIDTH-1], Z = (result == 0) always.
- MUL: shift-add, one bit of src1 per cycle, LSB first; result = low WIDTH bits of product.
- UDIV: restoring division, one quotient bit per cycle, MSB first; result = quotient. src1 == 0 → result all-ones, div_by_zero = 1, still WIDTH iterations.
- FSM: IDLE, MUL, DIV, DONE.
  - IDLE: in_ready = 1. Accept on in_valid: single-cycle ops compute and go to DONE; MUL/UDIV latch operands, clear counter, go to MUL/DIV.
  - MUL/DIV: one step per cycle; after step WIDTH go to DONE.
  - DONE: out_valid = 1, result/res_flags/div_by_zero stable. On out_ready: if latched set_flags, flags ← res_flags; go to IDLE.
- One operation in flight; no pipelining. in_ready = 0 outside IDLE.
- Reset values: in_ready 1 (after reset released), out_valid 0, result 0, res_flags 0, flags 0, div_by_zero 0, state IDLE, counter 0.

## Timing
- Request accepted in cycle T (in_valid & in_ready).
- Single-cycle op: out_valid high from T+1.
- MUL/UDIV: out_valid high from T+WIDTH+1.
- Result accepted in cycle R (out_valid & out_ready); flags updated visible R+1; in_ready high R+1; next request earliest R+1 (no same-cycle back-to-back).
- out_ready held low: outputs hold indefinitely.
- Carry-in sampled at T, so a set_flags result accepted at R affects requests from R+1.
- rst_n low at any edge (including mid-iteration or in DONE): aborts, returns to reset values next cycle; pending result and flag update discarded.

## Configuration
- ITER_ALU_DIV_EN defined: UDIV (1001) implemented as above, divider datapath present.
- Not defined: 1001 treated as reserved (result 0, res_flags 0, div_by_zero 0, single-cycle, DONE at T+1); no divider logic; DIV state unreachable.

## Test plan
- Reset: rst_n low 2 cycles → out_valid 0, in_ready 1, flags 0000, result 0.
- ADD WIDTH=32, 0xFFFFFFFF + 1, set_flags=1 → at T+1 result 0, res_flags 0110; after accept flags = 0110; following ADC 0+0 → result 1.
- SUB 5−7 → result 0xFFFFFFFE, N=1 C=0; SUB 0x80000000−1 → 0x7FFFFFFF, C=1 V=1.
- MUL 0x0001_0003 × 0x0001_0005 → out_valid exactly at T+33, result 0x0008_000F, C=0 V=0; out_ready held low 5 cycles → result stable, in_ready 0.
- UDIV (macro on) 100/7 → 14 at T+33; 5/0 → 0xFFFFFFFF, div_by_zero 1; macro off → 1001 returns 0 at T+1.
- Reset asserted at cycle 10 of MUL → out_valid never rises, in_ready 1 after release, flags unchanged at 0.
